unipolar_rz: RTL and testbench

// - Serialises a DATA_WIDTH-bit word onto a single-wire unipolar return-to-zero line, LSB first.
// - Each bit is a high pulse whose width encodes 0/1, then a low gap.
// - Words stream back-to-back on request; when the stream stops, a RESET_TIME low latch period follows.
// - Drives addressable LED strips (WS2812/SK6805 class) from the system clock domain.

---
 rtl/unipolar_rz_pkg.sv | 20 ++
 rtl/unipolar_rz.sv | 147 ++++++++++++++
 tb/tb_unipolar_rz.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unipolar_rz_pkg.sv
// Shared helpers for the unipolar return-to-zero serialiser.
//   time_to_cycles : converts a duration in seconds to a whole number of
//                    clock cycles, rounding to nearest.
//   max_int        : larger of two integers, used when deriving low widths.
//   counter_width  : bits needed to hold values 0..max_count.
package unipolar_rz_pkg;

  function automatic int time_to_cycles(real t, real rate);
    return int'($rtoi(t * rate + 0.5));
  endfunction

  function automatic int max_int(int a, int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int counter_width(int max_count);
    return (max_count < 2) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/unipolar_rz.sv
// Unipolar return-to-zero serialiser for WS2812/SK6805-class LED strips.
// Each data bit (LSB first) is sent as a high pulse whose width encodes the
// bit value, followed by a low gap. Words can stream back-to-back; when the
// stream stops, the line is held low for the latch time.
//
// Ports
//   clock    in   1           system clock
//   reset_n  in   1           asynchronous active-low reset
//   data     in   DATA_WIDTH  word, sampled only on the accept cycle
//   enable   in   1           request to send, sampled on the accept cycle
//   line     out  1           RZ output, low when idle (registered)
//   ready    out  1           accept window indicator
//
// State numbering: 0 idle, 2k+1 high phase of bit k, 2k+2 low phase of
// bit k, 2*DATA_WIDTH+1 latch gap. The time counter holds the remaining
// cycles of the current phase minus one; a phase ends when it reads 0.
module unipolar_rz
  import unipolar_rz_pkg::*;
#(
  parameter int  DATA_WIDTH     = 24,
  parameter real CLOCK_RATE     = 100e6,
  parameter real PERIOD_TIME    = 1.2e-6,
  parameter real ZERO_HIGH_TIME = 0.3e-6,
  parameter real ZERO_LOW_TIME  = 0.8e-6,
  parameter real ONE_HIGH_TIME  = 0.6e-6,
  parameter real ONE_LOW_TIME   = 0.2e-6,
  parameter real RESET_TIME     = 80e-6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  enable,
  output logic                  line,
  output logic                  ready
);

  localparam int H0 = time_to_cycles(ZERO_HIGH_TIME, CLOCK_RATE);
  localparam int H1 = time_to_cycles(ONE_HIGH_TIME, CLOCK_RATE);
  localparam int NP = time_to_cycles(PERIOD_TIME, CLOCK_RATE);
  // Low widths stretch so that every bit honours the minimum bit period.
  localparam int L0 = max_int(time_to_cycles(ZERO_LOW_TIME, CLOCK_RATE), NP - H0);
  localparam int L1 = max_int(time_to_cycles(ONE_LOW_TIME, CLOCK_RATE), NP - H1);
  localparam int R  = time_to_cycles(RESET_TIME, CLOCK_RATE);

  localparam int MAXC = max_int(max_int(R, max_int(L0, L1)), max_int(H0, H1));
  localparam int TW   = counter_width(MAXC);
  localparam int SW   = $clog2(2 * DATA_WIDTH + 2);

  localparam logic [SW-1:0] S_IDLE     = '0;
  localparam logic [SW-1:0] S_LAST_LOW = SW'(2 * DATA_WIDTH);
  localparam logic [SW-1:0] S_GAP      = SW'(2 * DATA_WIDTH + 1);

  localparam logic [TW-1:0] H0_M1 = TW'(H0 - 1);
  localparam logic [TW-1:0] H1_M1 = TW'(H1 - 1);
  localparam logic [TW-1:0] L0_M1 = TW'(L0 - 1);
  localparam logic [TW-1:0] L1_M1 = TW'(L1 - 1);
  localparam logic [TW-1:0] R_M1  = TW'(R - 1);

  if (H0 < 1 || H1 < 1 || L0 < 2 || L1 < 2) begin : g_bad_timing
    $error("unipolar_rz: pulse timing too short for CLOCK_RATE");
  end

  logic [SW-1:0]         r_state;
  logic [TW-1:0]         r_time;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_line;

  logic [SW-1:0]         w_state_nxt;
  logic [TW-1:0]         w_time_nxt;
  logic [DATA_WIDTH-1:0] w_shift_nxt;
  logic [DATA_WIDTH-1:0] w_shift_adv;
  logic                  w_phase_end;
  logic                  w_accept;
  logic                  w_line_nxt;
  logic [TW-1:0]         w_cap_high;
  logic [TW-1:0]         w_low_len;
  logic [TW-1:0]         w_next_high;

  assign w_phase_end = (r_time == '0);
  assign w_accept    = ((r_state == S_IDLE) && enable) ||
                       ((r_state == S_LAST_LOW) && w_phase_end);

  // Phase lengths: the bit currently being sent sits in r_shift[0]; the
  // following bit is read from the advanced copy so the next high phase is
  // loaded in the same cycle the register shifts.
  assign w_shift_adv = r_shift >> 1;
  assign w_cap_high  = data[0]        ? H1_M1 : H0_M1;
  assign w_low_len   = r_shift[0]     ? L1_M1 : L0_M1;
  assign w_next_high = w_shift_adv[0] ? H1_M1 : H0_M1;

  always_comb begin
    w_state_nxt = r_state;
    w_time_nxt  = r_time;
    w_shift_nxt = r_shift;
    if (w_accept) begin
      if (enable) begin
        w_shift_nxt = data;
        w_state_nxt = SW'(1);
        w_time_nxt  = w_cap_high;
      end else begin
        w_state_nxt = S_GAP;
        w_time_nxt  = R_M1;
      end
    end else if (r_state == S_IDLE) begin
      w_time_nxt = '0;
    end else if (!w_phase_end) begin
      w_time_nxt = r_time - TW'(1);
    end else if (r_state == S_GAP) begin
      w_state_nxt = S_IDLE;
      w_time_nxt  = '0;
    end else if (r_state[0]) begin
      // End of a high phase: drop into the low phase of the same bit.
      w_state_nxt = r_state + SW'(1);
      w_time_nxt  = w_low_len;
    end else begin
      // End of a low phase (not the last bit): start the next bit.
      w_state_nxt = r_state + SW'(1);
      w_time_nxt  = w_next_high;
      w_shift_nxt = w_shift_adv;
    end
  end

  // Line is registered from the next state so it is glitch-free yet tracks
  // the state exactly: high in every odd state except the latch gap.
  assign w_line_nxt = w_state_nxt[0] && (w_state_nxt != S_GAP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_time  <= '0;
      r_shift <= '0;
      r_line  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_time  <= w_time_nxt;
      r_shift <= w_shift_nxt;
      r_line  <= w_line_nxt;
    end
  end

  assign line  = r_line;
  // Ready leads the final low cycle by one so the requester can raise
  // enable exactly on the accept cycle without a wasted gap.
  assign ready = ((r_state == S_IDLE) && !enable) ||
                 ((r_state == S_LAST_LOW) && (r_time == TW'(1)));

endmodule

// File: tb/tb_unipolar_rz.sv
module tb_unipolar_rz;

  localparam int  DW     = 24;
  localparam real CLK_HZ = 100e6;

  function automatic int ncyc(real t);
    return int'($rtoi(t * CLK_HZ + 0.5));
  endfunction

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Expected pulse shapes straight from the timing rules.
  localparam int TH0 = ncyc(0.3e-6);
  localparam int TH1 = ncyc(0.6e-6);
  localparam int TL0 = imax(ncyc(0.8e-6), ncyc(1.2e-6) - TH0);
  localparam int TL1 = imax(ncyc(0.2e-6), ncyc(1.2e-6) - TH1);
  localparam int TR  = ncyc(80e-6);

  logic          clock = 1'b0;
  logic          reset_n;
  logic [DW-1:0] data;
  logic          enable;
  logic          line;
  logic          ready;

  unipolar_rz dut (
    .clock   (clock),
    .reset_n (reset_n),
    .data    (data),
    .enable  (enable),
    .line    (line),
    .ready   (ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit gap;
    int high;
    int low;
  } item_t;

  item_t exp_q[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a word becomes DW pulses, LSB first.
  task automatic push_word(input logic [DW-1:0] w);
    item_t it;
    for (int k = 0; k < DW; k++) begin
      it.gap  = 1'b0;
      it.high = w[k] ? TH1 : TH0;
      it.low  = w[k] ? TL1 : TL0;
      exp_q.push_back(it);
    end
  endtask

  task automatic push_gap();
    item_t it;
    it.gap  = 1'b1;
    it.high = 0;
    it.low  = 0;
    exp_q.push_back(it);
  endtask

  // Monitor: measures every pulse on the line and compares with the queue.
  int    mon_phase = 0;
  int    hi_cnt    = 0;
  int    lo_cnt    = 0;
  item_t cur;

  initial begin : monitor
    cur.gap = 1'b0; cur.high = 0; cur.low = 0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        mon_phase = 0; hi_cnt = 0; lo_cnt = 0;
      end else if (line) begin
        if (mon_phase != 1) begin
          if (mon_phase == 2) check("bit_low_cycles", lo_cnt, cur.low);
          else if (mon_phase == 3) check("gap_low_cycles", lo_cnt, cur.low + TR + 1);
          check("pulse_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("pulse_not_gap", cur.gap, 0);
          end else begin
            cur.gap = 1'b0; cur.high = 0; cur.low = 0;
          end
          mon_phase = 1;
          hi_cnt    = 0;
        end
        hi_cnt++;
      end else begin
        if (mon_phase == 1) begin
          check("bit_high_cycles", hi_cnt, cur.high);
          mon_phase = 2;
          lo_cnt    = 0;
        end
        if (mon_phase >= 2) lo_cnt++;
        if (mon_phase == 2 && lo_cnt == cur.low + 1) begin
          check("gap_expected", (exp_q.size() != 0) && exp_q[0].gap, 1);
          if (exp_q.size() != 0 && exp_q[0].gap) begin
            exp_q.delete(0);
            mon_phase = 3;
            check("gap_entry_state", dut.r_state, 2 * DW + 1);
            check("gap_entry_count", dut.r_time, TR - 1);
          end else begin
            mon_phase = 0;
          end
        end
        if (mon_phase == 3 && lo_cnt == cur.low + TR + 1) begin
          check("gap_end_state", dut.r_state, 0);
          check("gap_end_count", dut.r_time, 0);
          check("gap_end_ready", ready, 1);
          mon_phase = 0;
        end
      end
    end
  end

  task automatic wait_ready(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!ready && n < budget);
    check("ready_within_budget", ready, 1);
  endtask

  task automatic noise(input int cycles);
    repeat (cycles) begin
      @(posedge clock); #1;
      enable = 1'($urandom_range(0, 1));
      data   = DW'($urandom);
    end
    @(posedge clock); #1;
    enable = 1'b0;
  endtask

  task automatic start_idle(input logic [DW-1:0] w);
    wait_ready(100);
    check("idle_state_at_ready", dut.r_state, 0);
    @(posedge clock); #1;
    enable = 1'b1;
    data   = w;
    push_word(w);
    @(posedge clock); #1;
    enable = 1'b0;
    data   = DW'($urandom);
  endtask

  task automatic stream_next(input logic [DW-1:0] w, input bit go);
    wait_ready(4000);
    check("stream_ready_state", dut.r_state, 2 * DW);
    check("stream_ready_count", dut.r_time, 1);
    @(posedge clock); #1;
    if (go) begin
      enable = 1'b1;
      data   = w;
      push_word(w);
    end else begin
      push_gap();
    end
    @(posedge clock); #1;
    enable = 1'b0;
    data   = DW'($urandom);
  endtask

  task automatic send_stream(input logic [DW-1:0] words[$]);
    start_idle(words[0]);
    noise(2000);
    for (int i = 1; i < words.size(); i++) begin
      stream_next(words[i], 1'b1);
      noise(2000);
    end
    stream_next('0, 1'b0);
    noise(7000);
    wait_ready(3000);
    check("stream_done_state", dut.r_state, 0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [DW-1:0] words[$];
    logic [DW-1:0] w;
    reset_n = 1'b0;
    enable  = 1'b0;
    data    = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_line", line, 0);
    check("reset_ready", ready, 1);
    reset_n = 1'b1;

    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      check("idle_line", line, 0);
      check("idle_ready", ready, 1);
      check("idle_state", dut.r_state, 0);
      check("idle_count", dut.r_time, 0);
    end

    words = '{24'habcdef};
    send_stream(words);

    words = '{24'habcdef, 24'habcdf0, 24'habcdf1, 24'habcdf2};
    send_stream(words);

    words = '{DW'($urandom), DW'($urandom), DW'($urandom)};
    send_stream(words);

    // Async reset in the middle of a high phase of a 1 bit.
    w = DW'($urandom) | DW'(1);
    start_idle(w);
    repeat (20) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    check("midbit_reset_line", line, 0);
    check("midbit_reset_state", dut.r_state, 0);
    check("midbit_reset_count", dut.r_time, 0);
    check("midbit_reset_ready", ready, 1);
    exp_q.delete();
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    words = '{DW'($urandom)};
    send_stream(words);

    repeat (10) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);
    check("monitor_idle", mon_phase, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
